// File: rtl/a2_ring_pkg.sv
// Shared A2 timing definitions: legal Johnson ring codes, code-to-index lookup
// and the decoder state type.
package a2_ring_pkg;

  localparam int unsigned RING_LEN = 10;

  // Codes are {P05..P01}; entry i is ring index i.
  localparam logic [4:0] RING_CODES [RING_LEN] = '{
    5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
    5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000
  };

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } ring_st_t;

  // Returns {valid, idx[3:0]}; idx is 0 when the code is not in the table.
  function automatic logic [4:0] ring_idx(input logic [4:0] code);
    logic [4:0] r;
    r = '0;
    for (int unsigned i = 0; i < RING_LEN; i++) begin
      if (code == RING_CODES[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  function automatic logic [3:0] ring_next(input logic [3:0] idx);
    return (idx == 4'(RING_LEN - 1)) ? 4'd0 : idx + 4'd1;
  endfunction

endpackage

// File: rtl/a2_ring_check.sv
// Combinational ring checker: complement, legality and step-order faults on the
// registered ring bus, plus the decoded index of the current code.
module a2_ring_check
  import a2_ring_pkg::*;
(
  input  logic [4:0] CODE,
  input  logic [4:0] CODE_N,
  input  logic [4:0] PREV,
  output logic       F_CMP,
  output logic       F_ILL,
  output logic       F_SEQ,
  output logic       CHG,
  output logic [3:0] IDX
);

  logic [4:0] cur;
  logic [4:0] prv;

  always_comb begin
    cur   = ring_idx(CODE);
    prv   = ring_idx(PREV);
    CHG   = (CODE != PREV);
    F_CMP = (CODE != ~CODE_N);
    F_ILL = !cur[4];
    // Leaving an illegal code has no defined successor, so it is never a clean step.
    F_SEQ = CHG && cur[4] && (!prv[4] || (cur[3:0] != ring_next(prv[3:0])));
    IDX   = cur[3:0];
  end

endmodule

// File: rtl/a2_ring_decoder.sv
// A2 ring decoder: registers the ring bus, supervises it for faults and stalls,
// and drives one-hot time pulses once locked.
module a2_ring_decoder
  import a2_ring_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 2,
  parameter int unsigned STALL_MAX = 16,
  parameter int unsigned ERR_W     = 4
) (
  input  logic             SIM_CLK,
  input  logic             SIM_RST,
  input  logic [4:0]       P,
  input  logic [4:0]       P_,
  input  logic             STOP,
  output logic [9:0]       T,
  output logic [3:0]       TIDX,
  output logic             TPGOOD,
  output logic             TPALM,
  output logic [ERR_W-1:0] ERRCNT
);

  localparam int unsigned    STW        = $clog2(STALL_MAX) + 1;
  localparam int unsigned    CW         = $clog2(LOCK_CNT) + 1;
  localparam logic [STW-1:0] STALL_LAST = STW'(STALL_MAX - 1);
  localparam logic [CW-1:0]  LOCK_LAST  = CW'(LOCK_CNT - 1);

  logic [4:0]       p_q, pn_q, prev_q;
  logic             stop_q;
  logic [STW-1:0]   stall_q, stall_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  ring_st_t         st_q, st_d;
  logic [9:0]       t_q, t_d;
  logic [3:0]       tidx_q, tidx_d;
  logic             good_q, good_d;
  logic             alm_q, alm_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic       f_cmp, f_ill, f_seq, f_stl, chg, fault;
  logic [3:0] idx;

  a2_ring_check u_check (
    .CODE   (p_q),
    .CODE_N (pn_q),
    .PREV   (prev_q),
    .F_CMP  (f_cmp),
    .F_ILL  (f_ill),
    .F_SEQ  (f_seq),
    .CHG    (chg),
    .IDX    (idx)
  );

  // The timer saturates one short of the limit so a continuing stall keeps faulting.
  assign f_stl = !stop_q && !chg && (stall_q == STALL_LAST);
  assign fault = f_cmp | f_ill | f_seq | f_stl;

  always_comb begin
    stall_d = stall_q;
    if (chg) begin
      stall_d = '0;
    end else if (!stop_q && (stall_q != STALL_LAST)) begin
      stall_d = stall_q + 1'b1;
    end

    st_d   = st_q;
    cnt_d  = cnt_q;
    t_d    = '0;
    tidx_d = '0;
    good_d = 1'b0;
    alm_d  = 1'b0;
    err_d  = err_q;

    unique case (st_q)
      HUNT: begin
        if (fault) begin
          cnt_d = '0;
        end else if (chg) begin
          if (cnt_q == LOCK_LAST) begin
            st_d   = LOCKED;
            cnt_d  = '0;
            t_d    = 10'd1 << idx;
            tidx_d = idx;
            good_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOCKED: begin
        if (fault) begin
          st_d  = HUNT;
          cnt_d = '0;
          alm_d = 1'b1;
          if (err_q != '1) err_d = err_q + 1'b1;
        end else begin
          t_d    = 10'd1 << idx;
          tidx_d = idx;
          good_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      p_q     <= '0;
      pn_q    <= '1;
      prev_q  <= '0;
      stop_q  <= 1'b0;
      stall_q <= '0;
      cnt_q   <= '0;
      st_q    <= HUNT;
      t_q     <= '0;
      tidx_q  <= '0;
      good_q  <= 1'b0;
      alm_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      p_q     <= P;
      pn_q    <= P_;
      prev_q  <= p_q;
      stop_q  <= STOP;
      stall_q <= stall_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      t_q     <= t_d;
      tidx_q  <= tidx_d;
      good_q  <= good_d;
      alm_q   <= alm_d;
      err_q   <= err_d;
    end
  end

  assign T      = t_q;
  assign TIDX   = tidx_q;
  assign TPGOOD = good_q;
  assign TPALM  = alm_q;
  assign ERRCNT = err_q;

endmodule
